dac_tx_mixer: RTL and testbench

- Transmit-side IQ mixer feeding the DAC channels.
- Takes per-frequency I/Q carrier samples from the sine/cosine generator.
- For each DAC channel, forms a weighted sum of selected carriers: I·cos(θ) + Q·sin(θ), summed over MIX_NUM mixing slots.
- Emits one saturated 16-bit PCM sample per channel for each input valid strobe.
- Sits between the sincos generator and the DAC interface; its outputs also loop back to the receive mixer.

---
 rtl/dac_tx_mixer.sv | 125 ++++++++++++
 tb/tb_dac_tx_mixer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_tx_mixer.sv
// Transmit IQ mixer: per channel, sums I*cos + Q*sin over MIX_NUM selected carriers
// through a 3-stage pipeline and emits a saturated 16-bit PCM sample per input strobe.
module dac_tx_mixer #(
    parameter int unsigned CHANNEL  = 2,
    parameter int unsigned FREQ_NUM = 2,
    parameter int unsigned MIX_NUM  = 1
) (
    input  logic                            da_clk,
    input  logic                            rst_n,
    input  logic [16*FREQ_NUM-1:0]          ipcm_in,
    input  logic [16*FREQ_NUM-1:0]          qpcm_in,
    input  logic                            iqpcm_valid,
    input  logic [16*MIX_NUM*CHANNEL-1:0]   cos_sita,
    input  logic [16*MIX_NUM*CHANNEL-1:0]   sin_sita,
    input  logic [4*MIX_NUM*CHANNEL-1:0]    choose,
    output logic [CHANNEL-1:0]              dac_pcm_out_valid,
    output logic [16*CHANNEL-1:0]           dac_pcm_out
);

    localparam int unsigned SLOTS = CHANNEL * MIX_NUM;

    logic signed [15:0] sel_i [SLOTS];
    logic signed [15:0] sel_q [SLOTS];

    logic               v1;
    logic signed [15:0] i1   [SLOTS];
    logic signed [15:0] q1   [SLOTS];
    logic signed [15:0] cos1 [SLOTS];
    logic signed [15:0] sin1 [SLOTS];

    logic               v2;
    logic signed [31:0] p_ic [SLOTS];
    logic signed [31:0] p_qs [SLOTS];

    logic signed [35:0] acc;
    logic signed [35:0] shr;
    logic signed [15:0] sat  [CHANNEL];

    // Compare-based mux: out-of-range choose values match nothing and select zero.
    always_comb begin
        for (int unsigned s = 0; s < SLOTS; s++) begin
            sel_i[s] = '0;
            sel_q[s] = '0;
            for (int unsigned f = 0; f < FREQ_NUM; f++) begin
                if (choose[4*s +: 4] == 4'(f)) begin
                    sel_i[s] = ipcm_in[16*f +: 16];
                    sel_q[s] = qpcm_in[16*f +: 16];
                end
            end
        end
    end

    always_ff @(posedge da_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                i1[s]   <= '0;
                q1[s]   <= '0;
                cos1[s] <= '0;
                sin1[s] <= '0;
            end
        end else begin
            v1 <= iqpcm_valid;
            if (iqpcm_valid) begin
                for (int unsigned s = 0; s < SLOTS; s++) begin
                    i1[s]   <= sel_i[s];
                    q1[s]   <= sel_q[s];
                    cos1[s] <= cos_sita[16*s +: 16];
                    sin1[s] <= sin_sita[16*s +: 16];
                end
            end
        end
    end

    always_ff @(posedge da_clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                p_ic[s] <= '0;
                p_qs[s] <= '0;
            end
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int unsigned s = 0; s < SLOTS; s++) begin
                    p_ic[s] <= 32'(i1[s]) * 32'(cos1[s]);
                    p_qs[s] <= 32'(q1[s]) * 32'(sin1[s]);
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        shr = '0;
        for (int unsigned c = 0; c < CHANNEL; c++) begin
            acc = '0;
            for (int unsigned m = 0; m < MIX_NUM; m++) begin
                acc = acc + 36'(p_ic[c*MIX_NUM+m]) + 36'(p_qs[c*MIX_NUM+m]);
            end
            shr = acc >>> 12;
            if (shr > 36'sd32767)
                sat[c] = 16'sh7fff;
            else if (shr < -36'sd32768)
                sat[c] = 16'sh8000;
            else
                sat[c] = shr[15:0];
        end
    end

    always_ff @(posedge da_clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_pcm_out_valid <= '0;
            dac_pcm_out       <= '0;
        end else begin
            dac_pcm_out_valid <= {CHANNEL{v2}};
            if (v2) begin
                for (int unsigned c = 0; c < CHANNEL; c++) begin
                    dac_pcm_out[16*c +: 16] <= sat[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_tx_mixer.sv
// Self-checking bench for dac_tx_mixer: vector table, streaming/reset sequences and
// randomized traffic against an arithmetic reference model with a latency queue.
module tb_dac_tx_mixer;

    localparam int CHANNEL  = 2;
    localparam int FREQ_NUM = 2;
    localparam int MIX_NUM  = 1;
    localparam int SLOTS    = CHANNEL * MIX_NUM;

    logic                          da_clk = 1'b0;
    logic                          rst_n;
    logic [16*FREQ_NUM-1:0]        ipcm_in;
    logic [16*FREQ_NUM-1:0]        qpcm_in;
    logic                          iqpcm_valid;
    logic [16*SLOTS-1:0]           cos_sita;
    logic [16*SLOTS-1:0]           sin_sita;
    logic [4*SLOTS-1:0]            choose;
    logic [CHANNEL-1:0]            dac_pcm_out_valid;
    logic [16*CHANNEL-1:0]         dac_pcm_out;

    dac_tx_mixer #(
        .CHANNEL (CHANNEL),
        .FREQ_NUM(FREQ_NUM),
        .MIX_NUM (MIX_NUM)
    ) dut (
        .da_clk           (da_clk),
        .rst_n            (rst_n),
        .ipcm_in          (ipcm_in),
        .qpcm_in          (qpcm_in),
        .iqpcm_valid      (iqpcm_valid),
        .cos_sita         (cos_sita),
        .sin_sita         (sin_sita),
        .choose           (choose),
        .dac_pcm_out_valid(dac_pcm_out_valid),
        .dac_pcm_out      (dac_pcm_out)
    );

    always #5 da_clk = ~da_clk;

    typedef struct {
        int                    due;
        logic [16*CHANNEL-1:0] val;
    } exp_t;

    typedef struct {
        logic [15:0] ip0, ip1, qp0, qp1;
        logic [15:0] cs, sn;
        logic [3:0]  ch;
        logic [15:0] expect_out;
    } vec_t;

    exp_t                  pend[$];
    logic [16*CHANNEL-1:0] held;
    int                    cyc;
    int                    checks;
    int                    passes;
    logic [15:0]           obs_val[$];
    int                    obs_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    endtask

    // Reference: sum of products over the channel's slots, floor-divided by 4096, clamped.
    function automatic logic [15:0] model_chan(input int c);
        longint acc;
        longint t;
        acc = 0;
        for (int m = 0; m < MIX_NUM; m++) begin
            int s;
            int idx;
            logic signed [15:0] iv, qv, cv, sv;
            s   = c * MIX_NUM + m;
            idx = int'(choose[4*s +: 4]);
            iv  = 16'sd0;
            qv  = 16'sd0;
            if (idx < FREQ_NUM) begin
                iv = ipcm_in[16*idx +: 16];
                qv = qpcm_in[16*idx +: 16];
            end
            cv  = cos_sita[16*s +: 16];
            sv  = sin_sita[16*s +: 16];
            acc = acc + longint'(iv) * longint'(cv) + longint'(qv) * longint'(sv);
        end
        if (acc >= 0) t = acc / 4096;
        else          t = -((-acc + 4095) / 4096);
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        return t[15:0];
    endfunction

    task automatic step();
        exp_t e;
        if (iqpcm_valid === 1'b1 && rst_n === 1'b1) begin
            e.due = cyc + 3;
            for (int c = 0; c < CHANNEL; c++) e.val[16*c +: 16] = model_chan(c);
            pend.push_back(e);
        end
        @(posedge da_clk);
        #1;
        cyc++;
        if (dac_pcm_out_valid !== '0) begin
            obs_val.push_back(dac_pcm_out[15:0]);
            obs_cyc.push_back(cyc);
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            held = pend[0].val;
            void'(pend.pop_front());
            check("valid_strobe", 32'(dac_pcm_out_valid), 32'({CHANNEL{1'b1}}));
        end else begin
            check("valid_idle", 32'(dac_pcm_out_valid), 32'd0);
        end
        check("pcm_out", 32'(dac_pcm_out), 32'(held));
    endtask

    task automatic set_all(input logic [15:0] ip0, ip1, qp0, qp1, cs, sn, input logic [3:0] ch);
        ipcm_in  = {ip1, ip0};
        qpcm_in  = {qp1, qp0};
        cos_sita = {SLOTS{cs}};
        sin_sita = {SLOTS{sn}};
        choose   = {SLOTS{ch}};
    endtask

    vec_t vecs[7];

    initial begin
        cyc = 0; checks = 0; passes = 0; held = '0;
        rst_n = 1'b0; iqpcm_valid = 1'b0;
        set_all(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);

        vecs[0] = '{16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h1000, 4'd0,  16'h4000};
        vecs[1] = '{16'h0000, 16'h1000, 16'h0000, 16'h2000, 16'h0800, 16'h0800, 4'd1,  16'h1800};
        vecs[2] = '{16'h0000, 16'h1000, 16'h0000, 16'h2000, 16'h0800, 16'h0800, 4'd5,  16'h0000};
        vecs[3] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 4'd0,  16'h7FFF};
        vecs[4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h2000, 4'd0,  16'h8000};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 4'd0,  16'hFFFF};
        vecs[6] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 4'd15, 16'h0000};

        #12;
        check("reset_out", 32'(dac_pcm_out), 32'd0);
        check("reset_valid", 32'(dac_pcm_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge da_clk); #1;

        foreach (vecs[k]) begin
            set_all(vecs[k].ip0, vecs[k].ip1, vecs[k].qp0, vecs[k].qp1,
                    vecs[k].cs, vecs[k].sn, vecs[k].ch);
            iqpcm_valid = 1'b1;
            step();
            iqpcm_valid = 1'b0;
            step(); step(); step();
            for (int c = 0; c < CHANNEL; c++)
                check($sformatf("vec%0d_ch%0d", k, c), 32'(dac_pcm_out[16*c +: 16]),
                      32'(vecs[k].expect_out));
            step(); step();
            for (int c = 0; c < CHANNEL; c++)
                check($sformatf("vec%0d_hold_ch%0d", k, c), 32'(dac_pcm_out[16*c +: 16]),
                      32'(vecs[k].expect_out));
        end

        // Streaming: five back-to-back samples, weight changed right after the last.
        obs_val.delete(); obs_cyc.delete();
        for (int k = 1; k <= 5; k++) begin
            set_all(16'h0, 16'h0, 16'(k), 16'h0, 16'h0, 16'h1000, 4'd0);
            iqpcm_valid = 1'b1;
            step();
        end
        iqpcm_valid = 1'b0;
        sin_sita = {SLOTS{16'h0800}};
        for (int k = 0; k < 5; k++) step();
        check("stream_count", 32'(obs_val.size()), 32'd5);
        for (int k = 0; k < obs_val.size() && k < 5; k++) begin
            check($sformatf("stream_val%0d", k), 32'(obs_val[k]), 32'(k + 1));
            if (k > 0) check($sformatf("stream_gap%0d", k), 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd1);
        end

        // Reset while a sample is in flight.
        set_all(16'h0, 16'h0, 16'h3000, 16'h0, 16'h0, 16'h1000, 4'd0);
        iqpcm_valid = 1'b1;
        step();
        iqpcm_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(dac_pcm_out), 32'd0);
        check("async_reset_valid", 32'(dac_pcm_out_valid), 32'd0);
        pend.delete();
        held = '0;
        @(posedge da_clk); #3;
        rst_n = 1'b1;
        obs_val.delete(); obs_cyc.delete();
        for (int k = 0; k < 6; k++) step();
        check("no_strobe_after_reset", 32'(obs_val.size()), 32'd0);

        // Randomized traffic with independent per-channel settings.
        for (int k = 0; k < 400; k++) begin
            ipcm_in = {16'($urandom), 16'($urandom)};
            qpcm_in = {16'($urandom), 16'($urandom)};
            for (int s = 0; s < SLOTS; s++) begin
                cos_sita[16*s +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                                   : 16'($urandom_range(0, 16'h1000));
                sin_sita[16*s +: 16] = 16'($urandom);
                choose[4*s +: 4]     = ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                                                   : 4'($urandom_range(0, FREQ_NUM - 1));
            end
            iqpcm_valid = ($urandom_range(0, 9) < 7);
            step();
        end
        iqpcm_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("queue_drained", 32'(pend.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
